// File: rtl/input_debounce.sv
// input_debounce: two-flop synchronizer plus per-bit saturating counter debouncer with registered edge pulses
module input_debounce #(
    parameter int N = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] inputD,
    output logic [N-1:0] outputD,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         changed
);
    localparam int CW = $clog2(STABLE_CYCLES);
    logic [N-1:0]  s1, s2, differ, done;
    logic [CW-1:0] cnt [N];
    always_comb begin
        differ = s2 ^ outputD;
        for (int i = 0; i < N; i++)
            done[i] = differ[i] && cnt[i] == CW'(STABLE_CYCLES - 1);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            outputD <= '0;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < N; i++)
                cnt[i] <= '0;
        end else begin
            s1      <= inputD;
            s2      <= s1;
            outputD <= outputD ^ done;
            rise    <= done & s2;
            fall    <= done & ~s2;
            changed <= |done;
            // A bit counts only while it disagrees; a glitch or a qualification returns it to zero
            for (int i = 0; i < N; i++)
                cnt[i] <= (differ[i] && !done[i]) ? cnt[i] + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed scenarios plus randomized run against a sliding-window reference model
module tb_input_debounce;
    localparam int N = 2;
    localparam int SC = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] inputD = '0;
    logic [N-1:0] outputD, rise, fall;
    logic         changed;

    int tests = 0;
    int fails = 0;

    input_debounce #(.N(N), .STABLE_CYCLES(SC)) dut (
        .clock(clock), .reset(reset), .inputD(inputD),
        .outputD(outputD), .rise(rise), .fall(fall), .changed(changed)
    );

    always #5 clock = ~clock;

    // Reference: an output bit flips once the synchronized input has disagreed with it
    // for the last SC edges, all of them after the most recent reset.
    logic [N-1:0] m1 = '0, m2 = '0, mOut = '0, mRise = '0, mFall = '0;
    logic         mChg = 1'b0;
    logic [N-1:0] win [SC];
    int           sinceRst = 0;

    task automatic tick();
        logic [N-1:0] flip;
        @(posedge clock);
        if (reset) begin
            m1 = '0; m2 = '0; mOut = '0; mRise = '0; mFall = '0; mChg = 1'b0;
            sinceRst = 0;
        end else begin
            for (int j = SC - 1; j > 0; j--) win[j] = win[j-1];
            win[0] = m2;
            sinceRst++;
            for (int i = 0; i < N; i++) begin
                flip[i] = sinceRst >= SC;
                for (int j = 0; j < SC; j++)
                    if (win[j][i] == mOut[i]) flip[i] = 1'b0;
            end
            mRise = flip & ~mOut;
            mFall = flip & mOut;
            mOut  = mOut ^ flip;
            mChg  = |flip;
            m2 = m1;
            m1 = inputD;
        end
        @(negedge clock);
    endtask

    task automatic doReset();
        reset = 1'b1;
        inputD = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        tests++;
        if ({outputD, rise, fall, changed} !== 7'b0) begin
            fails++;
            $display("FAIL reset: got %b want %b", {outputD, rise, fall, changed}, 7'b0);
        end
    endtask

    task automatic test_single_rise();
        logic [6:0] want;
        inputD = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            want = {(e >= 6) ? 2'b01 : 2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00, e == 6};
            tests++;
            if ({outputD, rise, fall, changed} !== want) begin
                fails++;
                $display("FAIL single_rise edge %0d: got %b want %b", e, {outputD, rise, fall, changed}, want);
            end
        end
    endtask

    task automatic test_short_pulse();
        doReset();
        inputD = 2'b01;
        for (int e = 1; e <= 13; e++) begin
            if (e == 4) inputD = 2'b00;
            tick();
            tests++;
            if ({outputD, rise, fall, changed} !== 7'b0) begin
                fails++;
                $display("FAIL short_pulse edge %0d: got %b want %b", e, {outputD, rise, fall, changed}, 7'b0);
            end
        end
    endtask

    task automatic test_both_rise();
        logic [6:0] want;
        doReset();
        inputD = 2'b11;
        for (int e = 1; e <= 8; e++) begin
            tick();
            want = {(e >= 6) ? 2'b11 : 2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00, e == 6};
            tests++;
            if ({outputD, rise, fall, changed} !== want) begin
                fails++;
                $display("FAIL both_rise edge %0d: got %b want %b", e, {outputD, rise, fall, changed}, want);
            end
        end
    endtask

    task automatic test_single_fall();
        logic [6:0] want;
        inputD = 2'b10;
        for (int e = 1; e <= 8; e++) begin
            tick();
            want = {(e >= 6) ? 2'b10 : 2'b11, 2'b00, (e == 6) ? 2'b01 : 2'b00, e == 6};
            tests++;
            if ({outputD, rise, fall, changed} !== want) begin
                fails++;
                $display("FAIL single_fall edge %0d: got %b want %b", e, {outputD, rise, fall, changed}, want);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] want;
        doReset();
        inputD = 2'b01;
        for (int e = 1; e <= 4; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (outputD !== 2'b00) begin
            fails++;
            $display("FAIL mid_reset release: got %b want %b", outputD, 2'b00);
        end
        for (int e = 1; e <= 8; e++) begin
            tick();
            want = {(e >= 6) ? 2'b01 : 2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00, e == 6};
            tests++;
            if ({outputD, rise, fall, changed} !== want) begin
                fails++;
                $display("FAIL mid_reset edge %0d: got %b want %b", e, {outputD, rise, fall, changed}, want);
            end
        end
    endtask

    task automatic test_bounce();
        logic [1:0] pat [3];
        logic [6:0] want;
        doReset();
        pat[0] = 2'b00; pat[1] = 2'b10; pat[2] = 2'b00;
        for (int k = 0; k < 3; k++) begin
            inputD = pat[k];
            tick();
        end
        inputD = 2'b10;
        for (int e = 1; e <= 8; e++) begin
            tick();
            want = {(e >= 6) ? 2'b10 : 2'b00, (e == 6) ? 2'b10 : 2'b00, 2'b00, e == 6};
            tests++;
            if ({outputD, rise, fall, changed} !== want) begin
                fails++;
                $display("FAIL bounce edge %0d: got %b want %b", e, {outputD, rise, fall, changed}, want);
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        doReset();
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                inputD = N'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            reset = ($urandom_range(0, 199) == 0);
            tick();
            tests++;
            if ({outputD, rise, fall, changed} !== {mOut, mRise, mFall, mChg}) begin
                fails++;
                $display("FAIL random cycle %0d: got %b want %b", c, {outputD, rise, fall, changed}, {mOut, mRise, mFall, mChg});
            end
            tests++;
            if ((rise & fall) !== '0) begin
                fails++;
                $display("FAIL rise_fall_exclusive cycle %0d: got %b want %b", c, rise & fall, 2'b00);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int j = 0; j < SC; j++) win[j] = '0;
        @(negedge clock);
        test_reset();
        test_single_rise();
        test_short_pulse();
        test_both_rise();
        test_single_fall();
        test_mid_reset();
        test_bounce();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL have parameter N, default 2: width of the input and output data buses.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, legal range 2..256: consecutive differing samples required before an output bit changes.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 SHALL have port inputD, input, N bits: raw, asynchronous, possibly bouncing data from switches or pins.
REQ-006 SHALL have port outputD, output, N bits: debounced, registered data that feeds the downstream N-bit register bank.
REQ-007 SHALL have port rise, output, N bits: per-bit one-cycle pulse when outputD[i] goes 0->1.
REQ-008 SHALL have port fall, output, N bits: per-bit one-cycle pulse when outputD[i] goes 1->0.
REQ-009 SHALL have port changed, output, 1 bit: one-cycle pulse equal to the OR of all rise and fall bits in the same cycle.

Function
REQ-010 SHALL pass each inputD[i] through a two-flop synchronizer, s1[i] then s2[i]; no other logic shall read inputD or s1.
REQ-011 SHALL keep one counter per bit, cnt[i], of width ceil(log2(STABLE_CYCLES)); the counter shall never wrap.
REQ-012 Each bit SHALL be an independent two-state FSM:
- STABLE: s2[i]==outputD[i] and cnt[i]==0.
- PENDING: s2[i]!=outputD[i].
REQ-013 STABLE to PENDING: on an edge where s2[i]!=outputD[i], cnt[i] SHALL increment by 1.
REQ-014 PENDING with s2[i]!=outputD[i] and cnt[i]<STABLE_CYCLES-1: cnt[i] SHALL increment.
REQ-015 PENDING with s2[i]!=outputD[i] and cnt[i]==STABLE_CYCLES-1, on that edge:
- outputD[i] SHALL take s2[i].
- cnt[i] SHALL clear to 0.
- rise[i] or fall[i], whichever matches the direction, SHALL assert for exactly one cycle.
- The bit returns to STABLE.
REQ-016 PENDING with s2[i]==outputD[i] (glitch): cnt[i] SHALL clear to 0, the bit returns to STABLE, outputD[i] stays unchanged, and no pulse is produced.
REQ-017 Latency: an inputD[i] level held steady from before edge k SHALL appear on outputD[i] after edge k+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 clocks.
REQ-018 A pulse shorter than STABLE_CYCLES clocks on s2[i] SHALL never reach outputD[i].
REQ-019 Bits SHALL be fully independent; simultaneous qualification of several bits SHALL produce simultaneous pulses and one changed pulse.
REQ-020 rise, fall and changed SHALL be registered outputs, with no combinational path from inputD to any output.
REQ-021 rise[i] and fall[i] SHALL never both be 1 in the same cycle.

Reset
REQ-022 While reset=1 at an edge, s1, s2, cnt, outputD, rise, fall and changed SHALL all load 0.
REQ-023 Reset asserted mid-count SHALL discard the pending count; after release, counting SHALL restart from 0 against outputD=0.
REQ-024 With inputD held high through reset, outputD SHALL reach all ones exactly STABLE_CYCLES+2 clocks after the first edge with reset=0, with rise all ones for one cycle.

Verification
REQ-025 All scenarios use N=2, STABLE_CYCLES=4.
- Scenario 1: after reset, set inputD=01 and hold -> outputD=01 appears after the 6th edge; rise=01 and changed=1 for one cycle; fall=00 throughout.
- Scenario 2: from outputD=00, drive inputD[0]=1 for 3 clocks then 0 -> outputD stays 00; no rise, fall or changed pulse.
- Scenario 3: from outputD=00, drive inputD=11 and hold -> outputD=11 after 6 edges, with rise=11 and a single changed pulse.
- Scenario 4: from outputD=11, drive inputD=10 and hold -> outputD=10 after 6 edges; fall=01 for one cycle; outputD[1] does not toggle.
- Scenario 5: drive inputD=01, assert reset for one cycle 4 edges later, then release -> outputD=00 at release; outputD=01 appears 6 edges after release.
- Scenario 6: bounce inputD[1] 0,1,0,1 each for 1 clock, then hold 1 -> cnt[1] clears on each glitch; outputD[1]=1 exactly 6 edges after the final transition.
